// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine
// Sequential RSA modular exponentiation: result = base^exponent mod modulus.
// The loop is right-to-left square-and-multiply and consumes one exponent bit
// per clock. It finishes as soon as the remaining exponent is zero, so the
// latency is (index of highest set exponent bit + 2) cycles, or 1 cycle for
// exponent 0.
//
// Optional feature macro: RSA_MODEXP_ERRCHK_EN
//   defined   : a start with modulus == 0 bypasses RUN and reports
//               done=1, error=1, result=0 one cycle later.
//   undefined : error is tied low and modulus == 0 must not be used.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request, sampled only while idle
//   base      in   [WIDTH-1:0] message / ciphertext (may be >= modulus)
//   exponent  in   [WIDTH-1:0] e or d
//   modulus   in   [WIDTH-1:0] n
//   result    out  [WIDTH-1:0] last computed value, held until next completion
//   busy      out  high while the loop runs
//   done      out  one-cycle completion pulse
//   error     out  completion status, valid with done
module rsa_modexp_engine #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             error
);

`ifdef RSA_MODEXP_ERRCHK_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
`ifdef RSA_MODEXP_ERRCHK_EN
  logic             error_q, error_d;
`endif

  // Divisors are forced nonzero so the datapath never reduces by zero, even
  // in cycles whose result is discarded.
  logic [WIDTH-1:0] mod_in_safe;
  logic [WIDTH-1:0] m_safe;
  assign mod_in_safe = (modulus == '0) ? WIDTH'(1) : modulus;
  assign m_safe      = (m_q == '0) ? WIDTH'(1) : m_q;

  // (a*b) mod m with the full 2*WIDTH-bit product, so nothing is truncated.
  function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return WIDTH'(p % {{WIDTH{1'b0}}, m});
  endfunction

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    m_d      = m_q;
    e_d      = e_q;
    b_d      = b_q;
    acc_d    = acc_q;
`ifdef RSA_MODEXP_ERRCHK_EN
    error_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef RSA_MODEXP_ERRCHK_EN
          if (modulus == '0) begin
            state_d = S_ERR;
          end else
`endif
          begin
            m_d     = modulus;
            e_d     = exponent;
            b_d     = base % mod_in_safe;
            // 1 mod 1 is 0; otherwise the accumulator starts at 1.
            acc_d   = (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
            busy_d  = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (e_q == '0) begin
          result_d = acc_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          if (e_q[0]) begin
            acc_d = mod_mul(acc_q, b_q, m_safe);
          end
          b_d = mod_mul(b_q, b_q, m_safe);
          e_d = e_q >> 1;
        end
      end
`ifdef RSA_MODEXP_ERRCHK_EN
      S_ERR: begin
        result_d = '0;
        done_d   = 1'b1;
        error_d  = 1'b1;
        state_d  = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and visible outputs: reset to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef RSA_MODEXP_ERRCHK_EN
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef RSA_MODEXP_ERRCHK_EN
      error_q  <= error_d;
`endif
    end
  end

  // Working operands: always reloaded on start, so no reset needed.
  always_ff @(posedge clk) begin
    m_q   <= m_d;
    e_q   <= e_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
`ifdef RSA_MODEXP_ERRCHK_EN
  assign error  = error_q;
`else
  assign error  = 1'b0;
`endif

endmodule
